// File: rtl/rt_scan_scheduler.sv
// rt_scan_scheduler
// Two-pass channel scan controller for the RT grouping pipeline.
//   Pass 1 issues every channel to VPU memory and reduces the max-tree
//   returns into a tensor-wide maximum (tmax).
//   Pass 2 re-issues every channel with the frozen tmax so the index
//   generator can bin channels into groups.
//   Outstanding requests are bounded by MAX_INFLIGHT, and the pipeline is
//   drained before pass 2 starts and before the scan completes.
//
// Ports
//   clk          clock
//   rstn         synchronous reset, active-high (1 = reset)
//   start        one-cycle pulse, accepted only in IDLE or DONE
//   num_ch       channel count, latched on an accepted start
//   hold         downstream stall, blocks new issues while high
//   issue_valid  channel request valid (registered)
//   issue_chidx  channel address of the request
//   issue_tmax   tmax accompanying the request (0 in pass 1)
//   pass         0 = max search, 1 = grouping
//   max_valid    max-tree result valid (pass-1 return)
//   max_val      max-tree result, unsigned
//   grp_valid    index-generator result valid (pass-2 return)
//   tmax         running / final tensor max
//   busy         high while scanning or draining
//   done         one-cycle pulse on entering DONE
//   err          sticky: return seen with nothing in flight
//   scan_cycles  number of busy cycles of the current/last scan (saturating)
module rt_scan_scheduler #(
  parameter int CH_W         = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_INFLIGHT = 8,
  parameter int INF_W        = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [CH_W-1:0]       num_ch,
  input  logic                  hold,
  output logic                  issue_valid,
  output logic [CH_W-1:0]       issue_chidx,
  output logic [DATA_WIDTH-1:0] issue_tmax,
  output logic                  pass,
  input  logic                  max_valid,
  input  logic [DATA_WIDTH-1:0] max_val,
  input  logic                  grp_valid,
  output logic [DATA_WIDTH-1:0] tmax,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           scan_cycles
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN1  = 3'd1,
    ST_DRAIN1 = 3'd2,
    ST_SCAN2  = 3'd3,
    ST_DRAIN2 = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [INF_W-1:0] INF_MAX = INF_W'(MAX_INFLIGHT);

  // Saturating 32-bit increment for the cycle statistic.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

  // Unsigned maximum of two data words.
  function automatic logic [DATA_WIDTH-1:0] umax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  state_t                state_r;
  logic [CH_W-1:0]       num_ch_r;
  logic [CH_W-1:0]       ptr_r;
  logic [INF_W-1:0]      inflight_r;
  logic                  issue_valid_r;
  logic [CH_W-1:0]       issue_chidx_r;
  logic [DATA_WIDTH-1:0] issue_tmax_r;
  logic                  pass_r;
  logic [DATA_WIDTH-1:0] tmax_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  err_r;
  logic [31:0]           scan_cycles_r;

  logic                  ret_s;
  logic                  ret_ok_s;
  logic                  ret_err_s;
  logic                  scanning_s;
  logic                  can_issue_s;
  logic                  last_s;
  logic                  busy_state_s;
  logic [INF_W-1:0]      inflight_nxt_s;
  logic [DATA_WIDTH-1:0] tmax_nxt_s;

  // Return accounting, issue decision and next-cycle in-flight count.
  always_comb begin
    ret_s          = 1'b0;
    ret_ok_s       = 1'b0;
    ret_err_s      = 1'b0;
    scanning_s     = 1'b0;
    can_issue_s    = 1'b0;
    last_s         = 1'b0;
    busy_state_s   = 1'b0;
    inflight_nxt_s = inflight_r;
    tmax_nxt_s     = tmax_r;

    // Only the return type of the current pass counts; the other is ignored.
    if (pass_r) begin
      ret_s = grp_valid;
    end else begin
      ret_s = max_valid;
    end
    ret_ok_s  = ret_s && (inflight_r != {INF_W{1'b0}});
    ret_err_s = ret_s && (inflight_r == {INF_W{1'b0}});

    scanning_s   = (state_r == ST_SCAN1) || (state_r == ST_SCAN2);
    busy_state_s = (state_r == ST_SCAN1) || (state_r == ST_DRAIN1) ||
                   (state_r == ST_SCAN2) || (state_r == ST_DRAIN2);
    can_issue_s  = scanning_s && !hold && (inflight_r < INF_MAX);
    last_s       = (ptr_r == (num_ch_r - CH_W'(1)));

    case ({can_issue_s, ret_ok_s})
      2'b10:   inflight_nxt_s = inflight_r + INF_W'(1);
      2'b01:   inflight_nxt_s = inflight_r - INF_W'(1);
      default: inflight_nxt_s = inflight_r;
    endcase

    // tmax only follows max-tree results while pass 1 is active; it is frozen afterwards.
    if (((state_r == ST_SCAN1) || (state_r == ST_DRAIN1)) && max_valid) begin
      tmax_nxt_s = umax(tmax_r, max_val);
    end else begin
      tmax_nxt_s = tmax_r;
    end
  end

  // Scan FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_r       <= ST_IDLE;
      num_ch_r      <= {CH_W{1'b0}};
      ptr_r         <= {CH_W{1'b0}};
      inflight_r    <= {INF_W{1'b0}};
      issue_valid_r <= 1'b0;
      issue_chidx_r <= {CH_W{1'b0}};
      issue_tmax_r  <= {DATA_WIDTH{1'b0}};
      pass_r        <= 1'b0;
      tmax_r        <= {DATA_WIDTH{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      scan_cycles_r <= 32'd0;
    end else begin
      done_r        <= 1'b0;
      issue_valid_r <= 1'b0;
      inflight_r    <= inflight_nxt_s;
      tmax_r        <= tmax_nxt_s;
      if (ret_err_s) begin
        err_r <= 1'b1;
      end
      if (busy_state_s) begin
        scan_cycles_r <= sat_inc32(scan_cycles_r);
      end

      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            num_ch_r      <= num_ch;
            ptr_r         <= {CH_W{1'b0}};
            inflight_r    <= {INF_W{1'b0}};
            issue_chidx_r <= {CH_W{1'b0}};
            issue_tmax_r  <= {DATA_WIDTH{1'b0}};
            pass_r        <= 1'b0;
            tmax_r        <= {DATA_WIDTH{1'b0}};
            err_r         <= 1'b0;
            scan_cycles_r <= 32'd0;
            if (num_ch == {CH_W{1'b0}}) begin
              // Empty tensor: complete immediately without ever going busy.
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_SCAN1;
              busy_r  <= 1'b1;
            end
          end
        end

        ST_SCAN1: begin
          if (can_issue_s) begin
            issue_valid_r <= 1'b1;
            issue_chidx_r <= ptr_r;
            issue_tmax_r  <= {DATA_WIDTH{1'b0}};
            // The pointer parks on the last channel rather than wrapping.
            if (last_s) begin
              state_r <= ST_DRAIN1;
            end else begin
              ptr_r <= ptr_r + CH_W'(1);
            end
          end
        end

        ST_DRAIN1: begin
          // Leave as soon as the final pass-1 return is being absorbed.
          if (inflight_nxt_s == {INF_W{1'b0}}) begin
            state_r <= ST_SCAN2;
            ptr_r   <= {CH_W{1'b0}};
            pass_r  <= 1'b1;
          end
        end

        ST_SCAN2: begin
          if (can_issue_s) begin
            issue_valid_r <= 1'b1;
            issue_chidx_r <= ptr_r;
            issue_tmax_r  <= tmax_r;
            if (last_s) begin
              state_r <= ST_DRAIN2;
            end else begin
              ptr_r <= ptr_r + CH_W'(1);
            end
          end
        end

        ST_DRAIN2: begin
          if (inflight_nxt_s == {INF_W{1'b0}}) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign issue_valid = issue_valid_r;
  assign issue_chidx = issue_chidx_r;
  assign issue_tmax  = issue_tmax_r;
  assign pass        = pass_r;
  assign tmax        = tmax_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;
  assign scan_cycles = scan_cycles_r;

endmodule

// File: tb/tb_rt_scan_scheduler.sv
// Self-checking bench for rt_scan_scheduler: a table of scan scenarios
// (fixed and $urandom-generated) is run against a downstream model that
// returns each request after a delay, plus hand-written corner sequences.
module tb_rt_scan_scheduler;

  localparam int MAXI = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_ch = 16'd0;
  logic        hold = 1'b0;
  logic        max_valid = 1'b0;
  logic [15:0] max_val = 16'd0;
  logic        grp_valid = 1'b0;
  logic        issue_valid;
  logic [15:0] issue_chidx;
  logic [15:0] issue_tmax;
  logic        pass;
  logic [15:0] tmax;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] scan_cycles;

  rt_scan_scheduler #(.CH_W(16), .DATA_WIDTH(16), .MAX_INFLIGHT(8), .INF_W(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .num_ch(num_ch), .hold(hold),
    .issue_valid(issue_valid), .issue_chidx(issue_chidx), .issue_tmax(issue_tmax),
    .pass(pass), .max_valid(max_valid), .max_val(max_val), .grp_valid(grp_valid),
    .tmax(tmax), .busy(busy), .done(done), .err(err), .scan_cycles(scan_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n; int dmin; int dmax; int hold_at; int hold_len;
    int vmode; int poke; int exp_tmax; int exp_peak;
  } scen_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // downstream model: in-order return queue, one return per cycle
  int rq_due[$];
  int rq_val[$];
  bit rq_pass[$];
  int vals[256];
  int cur_n, cur_dmin, cur_dmax;
  int outstanding, peak, p1_cnt, p2_cnt, done_cnt, busy_cnt, model_max;
  bit hold_edge;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic init_model(input int n, input int dmin, input int dmax, input int vmode);
    int fixed_vals[4];
    fixed_vals = '{5, 9, 2, 7};
    rq_due.delete(); rq_val.delete(); rq_pass.delete();
    cur_n = n; cur_dmin = dmin; cur_dmax = dmax;
    outstanding = 0; peak = 0; p1_cnt = 0; p2_cnt = 0;
    done_cnt = 0; busy_cnt = 0; model_max = 0;
    for (int i = 0; i < 256; i++) begin
      if (vmode == 0) vals[i] = (i < 4) ? fixed_vals[i] : 0;
      else if (vmode == 2) vals[i] = 65535;
      else vals[i] = int'($urandom_range(65535, 0));
    end
  endtask

  // One clock: drive a due return, clock, then observe and score outputs.
  task automatic step();
    bit popped;
    bit rpass;
    bit epass;
    int rv;
    popped = 1'b0; rpass = 1'b0; rv = 0;
    max_valid = 1'b0; grp_valid = 1'b0; max_val = 16'd0;
    if (rq_due.size() > 0 && rq_due[0] <= cyc + 1) begin
      popped = 1'b1; rpass = rq_pass[0]; rv = rq_val[0];
      if (rpass) grp_valid = 1'b1;
      else begin max_valid = 1'b1; max_val = rv[15:0]; end
    end
    hold_edge = hold;
    @(posedge clk); #1;
    cyc++;
    max_valid = 1'b0; grp_valid = 1'b0; max_val = 16'd0;
    if (popped) begin
      void'(rq_due.pop_front()); void'(rq_val.pop_front()); void'(rq_pass.pop_front());
      outstanding--;
      if (!rpass && rv > model_max) model_max = rv;
    end
    if (issue_valid) begin
      epass = (p1_cnt < cur_n) ? 1'b0 : 1'b1;
      chk("issue_pass", pass, epass);
      chk("issue_in_hold", hold_edge, 0);
      if (!epass) begin
        chk("p1_chidx", issue_chidx, p1_cnt);
        chk("p1_issue_tmax", issue_tmax, 0);
        rq_val.push_back((p1_cnt < 256) ? vals[p1_cnt] : 0);
        p1_cnt++;
      end else begin
        chk("p2_chidx", issue_chidx, p2_cnt);
        chk("p2_issue_tmax", issue_tmax, model_max);
        rq_val.push_back(0);
        p2_cnt++;
      end
      rq_pass.push_back(epass);
      rq_due.push_back(cyc + int'($urandom_range(cur_dmax, cur_dmin)));
      outstanding++;
      if (outstanding > peak) peak = outstanding;
    end
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic pulse_max(input logic [15:0] v);
    max_valid = 1'b1; max_val = v;
    @(posedge clk); #1;
    cyc++;
    max_valid = 1'b0; max_val = 16'd0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_issue_valid"}, issue_valid, 0);
    chk({tag, "_issue_chidx"}, issue_chidx, 0);
    chk({tag, "_issue_tmax"}, issue_tmax, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_tmax"}, tmax, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_scan_cycles"}, scan_cycles, 0);
  endtask

  task automatic run_scan(input scen_t s);
    int lc;
    bit poked;
    init_model(s.n, s.dmin, s.dmax, s.vmode);
    num_ch = s.n[15:0]; start = 1'b1; hold = 1'b0;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_err", err, 0);
    chk("start_tmax", tmax, 0);
    chk("start_pass", pass, 0);
    lc = 0; poked = 1'b0;
    while (done_cnt == 0 && lc < 3000) begin
      hold = (lc >= s.hold_at) && (lc < s.hold_at + s.hold_len);
      if (s.poke != 0 && !poked && p2_cnt == 2) begin
        start = 1'b1; num_ch = 16'd2; poked = 1'b1;
      end
      step();
      if (start) begin
        start = 1'b0;
        chk("poke_pass", pass, 1);
        chk("poke_busy", busy, 1);
      end
      lc++;
    end
    hold = 1'b0;
    chk("done_seen", done_cnt, 1);
    chk("p1_count", p1_cnt, s.n);
    chk("p2_count", p2_cnt, s.n);
    chk("final_tmax", tmax, (s.exp_tmax >= 0) ? s.exp_tmax : model_max);
    chk("final_err", err, 0);
    chk("final_busy", busy, 0);
    chk("scan_cycles", scan_cycles, busy_cnt);
    chk("outstanding_zero", outstanding, 0);
    chk("peak_le_max", (peak <= MAXI) ? 1 : 0, 1);
    if (s.exp_peak > 0) chk("peak", peak, s.exp_peak);
    step();
    chk("done_one_cycle", done, 0);
  endtask

  scen_t tbl[12];

  initial begin
    // n, dmin, dmax, hold_at, hold_len, vmode, poke, exp_tmax, exp_peak
    tbl[0] = '{4, 3, 3, 100, 0, 0, 0, 9, 0};
    tbl[1] = '{20, 20, 20, 100, 0, 1, 0, -1, 8};
    tbl[2] = '{12, 2, 2, 3, 5, 1, 0, -1, 0};
    tbl[3] = '{1, 1, 1, 100, 0, 2, 0, 65535, 0};
    tbl[4] = '{8, 2, 2, 100, 0, 1, 1, -1, 0};
    tbl[5] = '{9, 1, 1, 0, 0, 1, 0, -1, 0};
    for (int i = 6; i < 12; i++) begin
      tbl[i].n        = int'($urandom_range(40, 1));
      tbl[i].dmin     = int'($urandom_range(5, 1));
      tbl[i].dmax     = tbl[i].dmin + int'($urandom_range(10, 0));
      tbl[i].hold_at  = int'($urandom_range(30, 0));
      tbl[i].hold_len = int'($urandom_range(6, 0));
      tbl[i].vmode    = 1;
      tbl[i].poke     = 0;
      tbl[i].exp_tmax = -1;
      tbl[i].exp_peak = 0;
    end

    // reset state
    init_model(0, 1, 1, 1);
    rstn = 1'b1;
    step(); step();
    chk_all_zero("reset");
    rstn = 1'b0;

    // return with nothing in flight while IDLE sets err
    pulse_max(16'd123);
    chk("idle_err", err, 1);
    chk("idle_busy", busy, 0);

    // empty scan: start clears err, done next cycle with tmax 0
    init_model(0, 1, 1, 1);
    num_ch = 16'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("n0_done", done, 1);
    chk("n0_err", err, 0);
    chk("n0_tmax", tmax, 0);
    chk("n0_busy", busy, 0);
    step();
    chk("n0_done_pulse", done, 0);

    for (int i = 0; i < 12; i++) run_scan(tbl[i]);

    // empty scan from DONE clears a nonzero tmax
    init_model(0, 1, 1, 1);
    num_ch = 16'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("n0b_done", done, 1);
    chk("n0b_tmax", tmax, 0);
    chk("n0b_scan_cycles", scan_cycles, 0);

    // reset in DRAIN2 with 3 in flight; late grp_valid must not set err
    init_model(3, 10, 10, 1);
    num_ch = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 300 && p2_cnt < 3; k++) step();
    chk("drain2_reached", p2_cnt, 3);
    chk("drain2_busy", busy, 1);
    rstn = 1'b1;
    step();
    rstn = 1'b0;
    chk_all_zero("midreset");
    for (int k = 0; k < 50 && rq_due.size() > 0; k++) step();
    chk("late_ret_drained", rq_due.size(), 0);
    chk("late_ret_err", err, 0);
    chk("late_ret_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
